// File: rtl/regbank32.sv
// regbank32: 32-entry MIPS register bank, two combinational read ports, one write port driven by a one-hot select.
// Define REGBANK32_BYPASS_EN to forward a qualified write to the read ports before the edge.
module regbank32 #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [31:0]      wsel,
    input  logic [WIDTH-1:0] wd,
    input  logic [4:0]       ra1,
    input  logic [4:0]       ra2,
    output logic [WIDTH-1:0] rd1,
    output logic [WIDTH-1:0] rd2,
    input  logic             err_clr,
    output logic             sel_err
);

    localparam int unsigned NREG = 32;
    localparam int unsigned AW   = 5;

    // Register 0 has no storage; it is synthesised as constant zero on the read side.
    logic [WIDTH-1:0] regs [1:NREG-1];

    logic          onehot;
    logic          wr_ok;
    logic          viol;
    logic [AW-1:0] widx;

    assign onehot = (wsel != '0) && ((wsel & (wsel - NREG'(1))) == '0);
    assign wr_ok  = we && onehot && !wsel[0];
    assign viol   = we && !onehot;

    // One-hot to binary index; only meaningful when onehot is set.
    always_comb begin
        widx = '0;
        for (int i = 0; i < NREG; i++) begin
            if (wsel[i]) widx = AW'(i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < NREG; i++) regs[i] <= '0;
        end else if (wr_ok) begin
            regs[widx] <= wd;
        end
    end

    // Violation wins over clear so a simultaneous clear cannot hide a new error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_err <= 1'b0;
        end else if (viol) begin
            sel_err <= 1'b1;
        end else if (err_clr) begin
            sel_err <= 1'b0;
        end
    end

    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (ra1 != '0) rd1 = regs[ra1];
        if (ra2 != '0) rd2 = regs[ra2];
`ifdef REGBANK32_BYPASS_EN
        // Forwarding is suppressed in reset so the ports read zero while rst_n is low.
        if (rst_n && wr_ok && (ra1 == widx)) rd1 = wd;
        if (rst_n && wr_ok && (ra2 == widx)) rd2 = wd;
`endif
    end

endmodule

// File: tb/tb_regbank32.sv
// Scoreboard bench for regbank32: stimulus pushes expected reads into a queue, a monitor pops and compares.
module tb_regbank32;

`ifdef REGBANK32_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        we;
    logic [31:0] wsel;
    logic [31:0] wd;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        err_clr;
    logic        sel_err;

    regbank32 #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .we(we), .wsel(wsel), .wd(wd),
        .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .err_clr(err_clr), .sel_err(sel_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          tag;
        logic [31:0] e1;
        logic [31:0] e2;
        logic        eerr;
    } exp_t;

    exp_t        q[$];
    logic [31:0] m [32];
    logic        m_err;
    int          tests = 0;
    int          fails = 0;
    int          tag_n = 0;
    event        chk_ev;

    // Expected read value from the architectural model, including write-through when enabled.
    function automatic logic [31:0] exp_rd(input logic [4:0] ra);
        logic [31:0] r;
        if (!rst_n || ra == 5'd0) return 32'd0;
        r = m[ra];
        if (BYP && we && $countones(wsel) == 1 && !wsel[0] && int'(ra) == $clog2(wsel))
            r = wd;
        return r;
    endfunction

    task automatic push();
        exp_t e;
        e.tag  = tag_n;
        e.e1   = exp_rd(ra1);
        e.e2   = exp_rd(ra2);
        e.eerr = rst_n ? m_err : 1'b0;
        tag_n++;
        q.push_back(e);
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) m[i] = 32'd0;
        m_err = 1'b0;
    endtask

    // Apply the architectural write/error rules at a rising edge.
    task automatic step();
        bit viol;
        @(posedge clk);
        if (rst_n) begin
            viol = we && ($countones(wsel) != 1);
            if (we && !viol && !wsel[0]) m[$clog2(wsel)] = wd;
            if (viol) m_err = 1'b1;
            else if (err_clr) m_err = 1'b0;
        end
        #1;
    endtask

    task automatic cyc(input logic w, input logic [31:0] s, input logic [31:0] d,
                       input logic [4:0] a1, input logic [4:0] a2, input logic c);
        we = w; wsel = s; wd = d; ra1 = a1; ra2 = a2; err_clr = c;
        push();
        step();
    endtask

    task automatic check(input int tag, input string nm, input logic [31:0] act, input logic [31:0] exv);
        tests++;
        if (act !== exv) begin
            fails++;
            $display("FAIL chk%0d %s: got %h expected %h", tag, nm, act, exv);
        end
    endtask

    // Monitor: compare every queued expectation at the falling edge or on an explicit mid-cycle sample.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk or chk_ev);
            while (q.size() > 0) begin
                e = q.pop_front();
                check(e.tag, "rd1", rd1, e.e1);
                check(e.tag, "rd2", rd2, e.e2);
                check(e.tag, "sel_err", 32'(sel_err), 32'(e.eerr));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] s;
        rst_n = 1'b0; we = 1'b0; wsel = '0; wd = '0; ra1 = '0; ra2 = '0; err_clr = 1'b0;
        model_clear();
        @(posedge clk); #1;

        // Held in reset: reads zero, writes ignored.
        cyc(1'b0, 32'h0, 32'h0, 5'd5, 5'd4, 1'b0);
        cyc(1'b1, 32'h20, 32'hDEAD_BEEF, 5'd5, 5'd4, 1'b0);
        rst_n = 1'b1;
        cyc(1'b0, 32'h0, 32'h0, 5'd5, 5'd4, 1'b0);

        cyc(1'b1, 32'h20, 32'hDEAD_BEEF, 5'd5, 5'd4, 1'b0);
        cyc(1'b0, 32'h0, 32'h0, 5'd5, 5'd4, 1'b0);

        // $zero discard.
        cyc(1'b1, 32'h1, 32'hFFFF_FFFF, 5'd0, 5'd0, 1'b0);
        cyc(1'b0, 32'h0, 32'h0, 5'd0, 5'd5, 1'b0);

        // Illegal selects and error clear priority.
        cyc(1'b1, 32'h2, 32'hAAAA, 5'd1, 5'd2, 1'b0);
        cyc(1'b1, 32'h4, 32'hBBBB, 5'd1, 5'd2, 1'b0);
        cyc(1'b1, 32'h6, 32'h1234, 5'd1, 5'd2, 1'b0);
        cyc(1'b1, 32'h0, 32'h1234, 5'd1, 5'd2, 1'b0);
        cyc(1'b0, 32'h0, 32'h0, 5'd1, 5'd2, 1'b1);
        cyc(1'b0, 32'h0, 32'h0, 5'd1, 5'd2, 1'b0);
        cyc(1'b1, 32'h3, 32'h0, 5'd1, 5'd2, 1'b1);
        cyc(1'b0, 32'h0, 32'h0, 5'd1, 5'd2, 1'b1);

        // we gating.
        cyc(1'b1, 32'h8000_0000, 32'h5A5A, 5'd31, 5'd0, 1'b0);
        cyc(1'b0, 32'h8000_0000, 32'hA5A5_A5A5, 5'd31, 5'd0, 1'b0);
        cyc(1'b0, 32'h0, 32'h0, 5'd31, 5'd0, 1'b0);

        // Write-through behaviour on reg 7.
        cyc(1'b1, 32'h80, 32'h1111, 5'd7, 5'd7, 1'b0);
        cyc(1'b1, 32'h80, 32'h2222, 5'd7, 5'd0, 1'b0);
        cyc(1'b0, 32'h0, 32'h0, 5'd7, 5'd7, 1'b0);

        // Asynchronous reset between edges while a write to reg 3 is pending.
        cyc(1'b1, 32'h8, 32'h3333, 5'd3, 5'd3, 1'b0);
        cyc(1'b1, 32'hC, 32'h0, 5'd3, 5'd3, 1'b0);
        we = 1'b1; wsel = 32'h8; wd = 32'h4444; ra1 = 5'd3; ra2 = 5'd3; err_clr = 1'b0;
        push();
        @(negedge clk); #1;
        rst_n = 1'b0;
        model_clear();
        #1;
        push();
        -> chk_ev;
        step();
        push();
        @(negedge clk); #1;
        we = 1'b0;
        rst_n = 1'b1;
        cyc(1'b0, 32'h0, 32'h0, 5'd3, 5'd3, 1'b0);

        // Randomised traffic.
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 9))
                0:       s = 32'h0;
                1:       s = $urandom;
                2:       s = 32'h1;
                default: s = 32'h1 << $urandom_range(0, 31);
            endcase
            cyc($urandom_range(0, 3) != 0, s, $urandom, 5'($urandom_range(0, 31)),
                5'($urandom_range(0, 31)), $urandom_range(0, 5) == 0);
        end

        repeat (2) @(negedge clk);
        #1;
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
